// File: rtl/vga_scanout_if.sv
// Scan-out bundle: frame-buffer read port, foreground colour and the VGA pin group.
interface vga_scanout_if;
    logic [2:0]  color;
    logic [17:0] raddr;
    logic        rdata;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        frame_start;

    modport master (
        input  color,
        input  rdata,
        output raddr,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hsync,
        output vga_vsync,
        output frame_start
    );

    modport slave (
        output color,
        output rdata,
        input  raddr,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hsync,
        input  vga_vsync,
        input  frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// 800x600@60 VGA scan-out of the 1bpp TRS-80 frame buffer: timing, line-doubled fetch,
// centred window with black borders, and a colour latched once per frame.
module vga_scanout #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 23,
    parameter int SRC_LINES   = 240,
    parameter int V_OFFSET    = 60,
    parameter int RAM_LATENCY = 1,
    parameter int LINE_STRIDE = 800
) (
    input  logic          vgaclk,
    input  logic          reset,
    vga_scanout_if.master bus
);
    localparam int HW  = 11;
    localparam int VW  = 10;
    localparam int AW  = 18;
    localparam int DLY = 1 + RAM_LATENCY;

    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VW-1:0] WIN_START = VW'(V_OFFSET);
    localparam logic [VW-1:0] WIN_END   = VW'(V_OFFSET + 2 * SRC_LINES);
    localparam logic [VW-1:0] WIN_LAST  = VW'(V_OFFSET + 2 * SRC_LINES - 1);
    localparam logic [AW-1:0] STRIDE    = AW'(LINE_STRIDE);

    typedef struct packed {
        logic active;
        logic in_window;
        logic hsync;
        logic vsync;
        logic first;
    } flags_t;

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [2:0]    color_latched_q, color_latched_d;
    flags_t        dly_q [DLY];
    flags_t        dly_d [DLY];
    logic [2:0]    rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;

    logic   h_last;
    logic   v_last;
    logic   win_line;
    logic   odd_line;
    logic   active;
    logic   in_window;
    logic   pix_on;
    flags_t flags_now;
    flags_t flags_out;

    // NOTE: every _d is given its hold value before any branch, so no path can infer a latch.
    always_comb begin
        h_last    = (hcount_q == H_LAST);
        v_last    = (vcount_q == V_LAST);
        win_line  = (vcount_q >= WIN_START) && (vcount_q < WIN_END);
        odd_line  = vcount_q[0] ^ WIN_START[0];
        active    = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        in_window = active && win_line;

        flags_now           = '0;
        flags_now.active    = active;
        flags_now.in_window = in_window;
        flags_now.hsync     = (hcount_q >= HS_START) && (hcount_q < HS_END);
        flags_now.vsync     = (vcount_q >= VS_START) && (vcount_q < VS_END);
        flags_now.first     = (hcount_q == '0) && (vcount_q == '0);

        hcount_d = h_last ? '0 : hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? '0 : vcount_q + VW'(1);
        end

        // Row base steps by one stride after the second copy of each source line,
        // except the last one, so it never points past the final source row.
        row_base_d = row_base_q;
        if (vcount_q == '0) begin
            row_base_d = '0;
        end else if (h_last && win_line && odd_line && (vcount_q != WIN_LAST)) begin
            row_base_d = row_base_q + STRIDE;
        end

        raddr_d = in_window ? row_base_q + AW'(hcount_q) : '0;

        color_latched_d = flags_now.first ? bus.color : color_latched_q;
    end

    // Sideband flags travel beside the RAM read so they meet rdata on the same cycle.
    always_comb begin
        dly_d[0] = flags_now;
        for (int i = 1; i < DLY; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        flags_out     = dly_q[DLY-1];
        pix_on        = bus.rdata & flags_out.in_window;
        rgb_d         = flags_out.active ? (color_latched_q & {3{pix_on}}) : 3'b000;
        hsync_d       = flags_out.hsync;
        vsync_d       = flags_out.vsync;
        frame_start_d = flags_out.first;
    end

    // NOTE: state updates use non-blocking assignments only; the delay line is reset
    // like any other flop because its stages directly gate the pins after reset.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hcount_q        <= '0;
            vcount_q        <= '0;
            row_base_q      <= '0;
            raddr_q         <= '0;
            color_latched_q <= 3'b111;
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= '0;
            end
            rgb_q           <= '0;
            hsync_q         <= 1'b0;
            vsync_q         <= 1'b0;
            frame_start_q   <= 1'b0;
        end else begin
            hcount_q        <= hcount_d;
            vcount_q        <= vcount_d;
            row_base_q      <= row_base_d;
            raddr_q         <= raddr_d;
            color_latched_q <= color_latched_d;
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= dly_d[i];
            end
            rgb_q           <= rgb_d;
            hsync_q         <= hsync_d;
            vsync_q         <= vsync_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign bus.raddr       = raddr_q;
    assign bus.vga_r       = rgb_q[2];
    assign bus.vga_g       = rgb_q[1];
    assign bus.vga_b       = rgb_q[0];
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two reduced-geometry builds (RAM latency 1 and 2) under a
// pixel scoreboard, plus a full 800x600 build checked against a cycle table.
module tb_vga_scanout;
    localparam int HA = 40, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 30, VFP = 1, VSW = 4, VBP = 3;
    localparam int SRC = 10, VOFF = 5, STRIDE = 40;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int LIT_ADDR = STRIDE * 5 + 10;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } pins_t;

    typedef struct {
        int         cyc;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] rgb;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] color;
    int         mode;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    vga_scanout_if if_a ();
    vga_scanout_if if_b ();
    vga_scanout_if if_f ();

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SRC_LINES(SRC), .V_OFFSET(VOFF), .RAM_LATENCY(1), .LINE_STRIDE(STRIDE)
    ) u_lat1 (.vgaclk(clk), .reset(reset), .bus(if_a));

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SRC_LINES(SRC), .V_OFFSET(VOFF), .RAM_LATENCY(2), .LINE_STRIDE(STRIDE)
    ) u_lat2 (.vgaclk(clk), .reset(reset), .bus(if_b));

    vga_scanout u_full (.vgaclk(clk), .reset(reset), .bus(if_f));

    function automatic logic ram_bit(input logic [17:0] a, input int m);
        if (m == 0) return (a == 18'(LIT_ADDR));
        return 1'b1;
    endfunction

    // Frame-buffer models: one and two cycles of read latency; the full build sees all ones.
    logic rd_a, rd_b1, rd_b2;
    always @(posedge clk) begin
        rd_a  <= ram_bit(if_a.raddr, mode);
        rd_b1 <= ram_bit(if_b.raddr, mode);
        rd_b2 <= rd_b1;
    end
    assign if_a.rdata = rd_a;
    assign if_b.rdata = rd_b2;
    assign if_f.rdata = 1'b1;
    assign if_a.color = color;
    assign if_b.color = color;
    assign if_f.color = color;

    pins_t pins_a, pins_b, pins_f;
    assign pins_a = {if_a.vga_r, if_a.vga_g, if_a.vga_b, if_a.vga_hsync, if_a.vga_vsync, if_a.frame_start};
    assign pins_b = {if_b.vga_r, if_b.vga_g, if_b.vga_b, if_b.vga_hsync, if_b.vga_vsync, if_b.frame_start};
    assign pins_f = {if_f.vga_r, if_f.vga_g, if_f.vga_b, if_f.vga_hsync, if_f.vga_vsync, if_f.frame_start};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_win(input int h, input int v);
        return (h < HA) && (v < VA) && (v >= VOFF) && (v < VOFF + 2 * SRC);
    endfunction

    function automatic logic [17:0] model_raddr(input int h, input int v);
        if (!in_win(h, v)) return 18'd0;
        return 18'(((v - VOFF) / 2) * STRIDE + h);
    endfunction

    function automatic pins_t model_pins(input int h, input int v, input logic [2:0] col, input int m);
        pins_t p;
        p    = '0;
        if (in_win(h, v) && ram_bit(model_raddr(h, v), m)) p.rgb = col;
        p.hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        p.vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
        p.fs = (h == 0) && (v == 0);
        return p;
    endfunction

    // Scoreboard: expected pins pushed as each counter position is scanned,
    // popped once the build's pipeline latency has elapsed.
    pins_t       q_a[$];
    pins_t       q_b[$];
    int          mh, mv, sb_cyc;
    logic [2:0]  mcol;
    logic [17:0] ra_prev;
    logic        have_prev;
    int          lit_a, lit_b, last_fs_a, last_fs_b, period_a, period_b;
    int          hs_run, hs_len, vs_run, vs_len, max_ra;

    always @(negedge clk) begin
        if (reset) begin
            q_a.delete();
            q_b.delete();
            mh = 0; mv = 0; sb_cyc = 0; have_prev = 1'b0;
            lit_a = 0; lit_b = 0; last_fs_a = -1; last_fs_b = -1; period_a = 0; period_b = 0;
            hs_run = 0; hs_len = 0; vs_run = 0; vs_len = 0; max_ra = 0;
        end else begin
            pins_t e;
            if (mh == 0 && mv == 0) mcol = color;
            e = model_pins(mh, mv, mcol, mode);
            q_a.push_back(e);
            q_b.push_back(e);
            if (q_a.size() > 3) check("pins_lat1", pins_a, q_a.pop_front());
            if (q_b.size() > 4) check("pins_lat2", pins_b, q_b.pop_front());
            if (have_prev) begin
                check("raddr_lat1", if_a.raddr, ra_prev);
                check("raddr_lat2", if_b.raddr, ra_prev);
            end
            ra_prev   = model_raddr(mh, mv);
            have_prev = 1'b1;

            if (pins_a.rgb != 3'b000) lit_a++;
            if (pins_b.rgb != 3'b000) lit_b++;
            if (int'(if_a.raddr) > max_ra) max_ra = int'(if_a.raddr);
            if (pins_a.fs) begin
                if (last_fs_a >= 0) period_a = sb_cyc - last_fs_a;
                last_fs_a = sb_cyc;
            end
            if (pins_b.fs) begin
                if (last_fs_b >= 0) period_b = sb_cyc - last_fs_b;
                last_fs_b = sb_cyc;
            end
            if (pins_a.hs) hs_run++;
            else if (hs_run > 0) begin hs_len = hs_run; hs_run = 0; end
            if (pins_a.vs) vs_run++;
            else if (vs_run > 0) begin vs_len = vs_run; vs_run = 0; end

            sb_cyc++;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
    end

    // Waits until the reduced-build counters sit at (h, v) right after a rising edge.
    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(mh == h && mv == v) && n < 3 * FRAME);
        if (!(mh == h && mv == v)) begin
            n_vec++;
            n_err++;
            $display("FAIL goto: position x=%0d y=%0d not reached, got x=%0d y=%0d", h, v, mh, mv);
        end
    endtask

    vec_t tbl [10];

    initial begin
        // Full 800x600 build, cycle index counted from the first cycle after reset release.
        tbl[0] = '{2,    1'b0, 1'b0, 1'b0, 3'b000};
        tbl[1] = '{3,    1'b0, 1'b0, 1'b1, 3'b000};
        tbl[2] = '{4,    1'b0, 1'b0, 1'b0, 3'b000};
        tbl[3] = '{842,  1'b0, 1'b0, 1'b0, 3'b000};
        tbl[4] = '{843,  1'b1, 1'b0, 1'b0, 3'b000};
        tbl[5] = '{970,  1'b1, 1'b0, 1'b0, 3'b000};
        tbl[6] = '{971,  1'b0, 1'b0, 1'b0, 3'b000};
        tbl[7] = '{1059, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[8] = '{1898, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[9] = '{1899, 1'b1, 1'b0, 1'b0, 3'b000};

        reset = 1'b1;
        color = 3'b110;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins_lat1", pins_a, 6'd0);
        check("reset_pins_lat2", pins_b, 6'd0);
        check("reset_pins_full", pins_f, 6'd0);
        check("reset_raddr_lat1", if_a.raddr, 18'd0);
        check("reset_raddr_full", if_f.raddr, 18'd0);

        // Phase 1: single lit source pixel, sync geometry over two frames.
        @(posedge clk);
        #2 reset = 1'b0;
        begin
            int ti;
            ti = 0;
            for (int cyc = 0; cyc < 2 * FRAME + 8; cyc++) begin
                @(negedge clk);
                if (ti < 10 && tbl[ti].cyc == cyc) begin
                    check($sformatf("full_hs_c%0d", cyc), pins_f.hs, tbl[ti].hs);
                    check($sformatf("full_vs_c%0d", cyc), pins_f.vs, tbl[ti].vs);
                    check($sformatf("full_fs_c%0d", cyc), pins_f.fs, tbl[ti].fs);
                    check($sformatf("full_rgb_c%0d", cyc), pins_f.rgb, tbl[ti].rgb);
                    ti++;
                end
            end
        end
        check("lit_count_lat1", lit_a, 4);
        check("lit_count_lat2", lit_b, 4);
        check("frame_period_lat1", period_a, FRAME);
        check("frame_period_lat2", period_b, FRAME);
        check("hsync_width", hs_len, HSW);
        check("vsync_width", vs_len, VSW * HT);

        // Phase 2: all-ones frame buffer, colour changed mid-frame, then reset mid-frame.
        @(posedge clk);
        #2 reset = 1'b1;
        mode  = 1;
        color = 3'b010;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        goto(0, 12);
        #2 color = 3'b100;
        goto(3, 14);
        repeat (3) @(posedge clk);
        #1 check("colour_frame0_lat1", pins_a.rgb, 3'b010);
        @(posedge clk);
        #1 check("colour_frame0_lat2", pins_b.rgb, 3'b010);
        goto(0, 1);
        goto(3, 14);
        repeat (3) @(posedge clk);
        #1 check("colour_frame1_lat1", pins_a.rgb, 3'b100);
        @(posedge clk);
        #1 check("colour_frame1_lat2", pins_b.rgb, 3'b100);
        check("raddr_max", max_ra, (SRC - 1) * STRIDE + HA - 1);

        goto(20, 20);
        #2 reset = 1'b1;
        #1;
        check("midreset_pins_lat1", pins_a, 6'd0);
        check("midreset_pins_lat2", pins_b, 6'd0);
        check("midreset_raddr_lat1", if_a.raddr, 18'd0);
        check("midreset_raddr_lat2", if_b.raddr, 18'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_fs_early_lat1", pins_a.fs, 1'b0);
        @(negedge clk);
        check("restart_fs_lat1", pins_a.fs, 1'b1);
        check("restart_fs_early_lat2", pins_b.fs, 1'b0);
        @(negedge clk);
        check("restart_fs_lat2", pins_b.fs, 1'b1);
        check("restart_fs_after_lat1", pins_a.fs, 1'b0);
        repeat (FRAME + 10) @(negedge clk);
        check("restart_period_lat1", period_a, FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
